// File: rtl/dvp_capture.sv
// dvp_capture: DVP/RGB565 sensor capture that skips SKIP_FRAMES frames after reset, then emits pixels (frame stats when DVP_FRAME_STATS_EN is defined)
module dvp_capture #(
   parameter int SKIP_FRAMES = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmos_vsync,
   input  logic        cmos_href,
   input  logic [7:0]  cmos_db,
   output logic        vin_vs,
   output logic        vin_de,
   output logic [15:0] vin_data,
   output logic        capture_ok,
   output logic [11:0] line_pixels,
   output logic [11:0] frame_lines
);
   typedef enum logic {SKIP, RUN} state_t;
   state_t state, state_nx;
   logic [7:0] skip_cnt, skip_cnt_nx;
   logic vs1, href1, vs2, tog, pair_v;
   logic [7:0] db1, hi;
   logic [15:0] pair_d;
   logic vs_rise, act;
   assign vs_rise = vs1 & ~vs2;
   assign act = href1 & ~vs1;
   assign capture_ok = state == RUN;
   assign vin_vs = capture_ok & vs2;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs1 <= 1'b0;
         href1 <= 1'b0;
         db1 <= '0;
         vs2 <= 1'b0;
         tog <= 1'b0;
         hi <= '0;
         pair_v <= 1'b0;
         pair_d <= '0;
         vin_de <= 1'b0;
         vin_data <= '0;
         state <= SKIP;
         skip_cnt <= '0;
      end else begin
         vs1 <= cmos_vsync;
         href1 <= cmos_href;
         db1 <= cmos_db;
         vs2 <= vs1;
         tog <= act ? ~tog : 1'b0;
         if (act & ~tog) hi <= db1;
         pair_v <= act & tog;
         if (act & tog) pair_d <= {hi, db1};
         vin_de <= pair_v & capture_ok;
         if (pair_v & capture_ok) vin_data <= pair_d;
         state <= state_nx;
         skip_cnt <= skip_cnt_nx;
      end
   end
   always_comb begin
      state_nx = state;
      skip_cnt_nx = skip_cnt;
      if (state == SKIP && vs_rise) begin
         if (skip_cnt == 8'(SKIP_FRAMES - 1)) state_nx = RUN;
         else skip_cnt_nx = skip_cnt + 8'd1;
      end
   end
`ifdef DVP_FRAME_STATS_EN
   logic href2;
   logic [11:0] pcnt, lcnt;
   logic href_fall;
   assign href_fall = ~href1 & href2;
   function automatic logic [11:0] sat_inc(input logic [11:0] a, input logic inc);
      return (a == 12'hFFF) ? a : a + 12'(inc);
   endfunction
   // pair_v is counted rather than vin_de so the line's last pixel is included when href falls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         href2 <= 1'b0;
         pcnt <= '0;
         lcnt <= '0;
         line_pixels <= '0;
         frame_lines <= '0;
      end else begin
         href2 <= href1;
         pcnt <= href_fall ? 12'd0 : sat_inc(pcnt, pair_v);
         if (href_fall) line_pixels <= sat_inc(pcnt, pair_v);
         lcnt <= vs_rise ? 12'd0 : sat_inc(lcnt, href_fall);
         if (vs_rise) frame_lines <= sat_inc(lcnt, href_fall);
      end
   end
`else
   assign line_pixels = '0;
   assign frame_lines = '0;
`endif
endmodule

// File: tb/tb_dvp_capture.sv
// tb_dvp_capture: randomized and directed checks of dvp_capture against a pixel-queue reference model
module tb_dvp_capture;
   localparam int SKIP = 2;
   logic clk = 1'b0, rst_n = 1'b0, cmos_vsync = 1'b0, cmos_href = 1'b0;
   logic [7:0] cmos_db = '0;
   logic vin_vs, vin_de, capture_ok;
   logic [15:0] vin_data;
   logic [11:0] line_pixels, frame_lines;
   dvp_capture #(.SKIP_FRAMES(SKIP)) dut (
      .clk(clk), .rst_n(rst_n), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href), .cmos_db(cmos_db),
      .vin_vs(vin_vs), .vin_de(vin_de), .vin_data(vin_data), .capture_ok(capture_ok),
      .line_pixels(line_pixels), .frame_lines(frame_lines)
   );
   always #5 clk = ~clk;
   typedef struct {logic [15:0] d; int c;} px_t;
   px_t q[$];
   px_t p;
   int cyc = 0, errors = 0, checks = 0, vs_count = 0, lines_m = 0;
   bit run_m = 1'b0;
   logic [15:0] last = '0;
   logic [7:0] seq = 8'h12, hi_m = '0;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic drive(input logic v, input logic h, input logic [7:0] d);
      @(negedge clk);
      cmos_vsync = v;
      cmos_href = h;
      cmos_db = d;
   endtask
   task automatic vpulse();
      int fl;
      vs_count++;
      if (vs_count >= SKIP) run_m = 1'b1;
      fl = lines_m;
      lines_m = 0;
      seq = 8'h12;
      repeat (4) drive(1'b1, 1'b0, 8'h00);
      chk("capture_ok", 32'(capture_ok), 32'(run_m));
      chk("vin_vs", 32'(vin_vs), 32'(run_m));
`ifdef DVP_FRAME_STATS_EN
      chk("frame_lines", 32'(frame_lines), 32'(fl > 4095 ? 4095 : fl));
`endif
      repeat (2) drive(1'b0, 1'b0, 8'h00);
   endtask
   task automatic line(input int n, input bit rnd);
      logic [7:0] b;
      for (int i = 0; i < n; i++) begin
         b = rnd ? 8'($urandom) : seq;
         if (!rnd) seq = seq + 8'h22;
         drive(1'b0, 1'b1, b);
         if (i % 2 == 0) hi_m = b;
         else if (run_m) q.push_back('{{hi_m, b}, cyc + 3});
      end
      lines_m++;
      repeat (3) drive(1'b0, 1'b0, 8'h00);
`ifdef DVP_FRAME_STATS_EN
      chk("line_pixels", 32'(line_pixels), 32'((n / 2) > 4095 ? 4095 : n / 2));
`endif
   endtask
   always @(negedge clk) begin
      if (!rst_n) last = '0;
      else if (vin_de) begin
         chk("de_expected", 32'(vin_de), 32'(q.size() > 0));
         if (q.size() > 0) begin
            p = q.pop_front();
            chk("pix_data", 32'(vin_data), 32'(p.d));
            chk("pix_cycle", 32'(cyc), 32'(p.c));
            last = p.d;
         end
      end else chk("data_hold", 32'(vin_data), 32'(last));
   end
   initial begin
      repeat (3) @(negedge clk);
      chk("rst_vin_vs", 32'(vin_vs), 0);
      chk("rst_vin_de", 32'(vin_de), 0);
      chk("rst_vin_data", 32'(vin_data), 0);
      chk("rst_capture_ok", 32'(capture_ok), 0);
      chk("rst_line_pixels", 32'(line_pixels), 0);
      chk("rst_frame_lines", 32'(frame_lines), 0);
      rst_n = 1'b1;
      for (int f = 0; f < 3; f++) begin
         vpulse();
         line(8, 1'b0);
         line(8, 1'b0);
      end
      begin
         drive(1'b0, 1'b1, 8'hAB);
         drive(1'b0, 1'b1, 8'hCD);
         q.push_back('{16'hABCD, cyc + 3});
         lines_m++;
         drive(1'b0, 1'b0, 8'h00);
         repeat (2) @(posedge clk);
         #1;
         chk("lat_de_n2", 32'(vin_de), 1);
         chk("lat_data_n2", 32'(vin_data), 32'h0000ABCD);
         @(posedge clk);
         #1;
         chk("lat_de_n3", 32'(vin_de), 0);
         repeat (2) drive(1'b0, 1'b0, 8'h00);
      end
      line(5, 1'b1);
      line(4, 1'b1);
      for (int f = 0; f < 3; f++) begin
         vpulse();
         for (int l = 0; l < 1 + int'($urandom % 3); l++) line(1 + int'($urandom % 9), 1'b1);
      end
      drive(1'b0, 1'b1, 8'hAB);
      drive(1'b0, 1'b1, 8'hCD);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_vin_vs", 32'(vin_vs), 0);
      chk("mid_vin_de", 32'(vin_de), 0);
      chk("mid_vin_data", 32'(vin_data), 0);
      chk("mid_capture_ok", 32'(capture_ok), 0);
      chk("mid_line_pixels", 32'(line_pixels), 0);
      chk("mid_frame_lines", 32'(frame_lines), 0);
      cmos_href = 1'b0;
      cmos_db = '0;
      vs_count = 0;
      run_m = 1'b0;
      lines_m = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      vpulse();
      line(6, 1'b1);
      vpulse();
      line(6, 1'b1);
      line(3, 1'b1);
`ifdef DVP_FRAME_STATS_EN
      line(10000, 1'b1);
      vpulse();
`else
      chk("stat_line_pixels", 32'(line_pixels), 0);
      chk("stat_frame_lines", 32'(frame_lines), 0);
`endif
      repeat (5) drive(1'b0, 1'b0, 8'h00);
      chk("queue_empty", 32'(q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
